bus_arbiter: RTL and testbench

- Registered arbiter that shares the main system bus between three masters: CPU, OAM DMA engine, and the UART debug/loader port.
- Replaces the combinational CPU/DMA bus steering at the top level.
- Issues grants, muxes address/data/strobes to the bus, and returns read data only to the current owner.
- Sits between the masters and the memory-mapped peripherals (PPU, timer, joypad, link, cartridge, low RAM). CPU-private paths (high RAM, interrupt regs) stay outside it.

---
 rtl/bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Registered three-master bus arbiter (CPU, OAM DMA, UART debug) with
// turnaround gap, hold limit for non-preemptive owners and owner-only read return.
module bus_arbiter #(
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  output logic        cpu_gnt,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_outdata,
  input  logic        cpu_load,
  input  logic        cpu_store,
  output logic [7:0]  cpu_indata,
  input  logic        dma_req,
  output logic        dma_gnt,
  input  logic [15:0] dma_address,
  input  logic [7:0]  dma_outdata,
  input  logic        dma_load,
  input  logic        dma_store,
  output logic [7:0]  dma_indata,
  input  logic        dbg_req,
  output logic        dbg_gnt,
  input  logic [15:0] dbg_address,
  input  logic [7:0]  dbg_outdata,
  input  logic        dbg_load,
  input  logic        dbg_store,
  output logic [7:0]  dbg_indata,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_outdata,
  output logic        bus_load,
  output logic        bus_store,
  input  logic [7:0]  bus_indata,
  output logic [1:0]  owner,
  output logic        timeout
);

  typedef enum logic [2:0] {S_IDLE, S_CPU, S_DMA, S_DBG, S_TURN} state_t;

  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [TW-1:0] TURN_LOAD = TW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t          state_q, state_d;
  logic [TW-1:0]   turn_q, turn_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            timeout_q, timeout_d;
  logic            release_c;
  logic            exclDma_c, exclDbg_c;

  function automatic state_t pick(input logic c, input logic d, input logic g);
    if (g)      return S_DBG;
    else if (d) return S_DMA;
    else if (c) return S_CPU;
    else        return S_IDLE;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      turn_q    <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      turn_q    <= turn_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    turn_d    = turn_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;
    release_c = 1'b0;
    exclDma_c = 1'b0;
    exclDbg_c = 1'b0;
    case (state_q)
      S_IDLE: state_d = pick(cpu_req, dma_req, dbg_req);
      S_CPU: begin
        if (dma_req || dbg_req || !cpu_req) release_c = 1'b1;
      end
      S_DMA: begin
        if (!dma_req) begin
          release_c = 1'b1;
        end else if (MAX_HOLD > 0 && hold_q == HOLD_LAST && (cpu_req || dbg_req)) begin
          release_c = 1'b1;
          timeout_d = 1'b1;
          exclDma_c = 1'b1;
        end else if (MAX_HOLD > 0 && hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_DBG: begin
        if (!dbg_req) begin
          release_c = 1'b1;
        end else if (MAX_HOLD > 0 && hold_q == HOLD_LAST && (cpu_req || dma_req)) begin
          release_c = 1'b1;
          timeout_d = 1'b1;
          exclDbg_c = 1'b1;
        end else if (MAX_HOLD > 0 && hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_TURN: begin
        if (turn_q == '0) state_d = pick(cpu_req, dma_req, dbg_req);
        else              turn_d  = turn_q - TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Without a turnaround gap the forced-out owner must not win its own release.
    if (release_c) begin
      if (TURNAROUND == 0) begin
        state_d = pick(cpu_req, dma_req && !exclDma_c, dbg_req && !exclDbg_c);
      end else begin
        state_d = S_TURN;
        turn_d  = TURN_LOAD;
      end
    end
    if (state_d != state_q) hold_d = '0;
  end

  assign cpu_gnt = (state_q == S_CPU);
  assign dma_gnt = (state_q == S_DMA);
  assign dbg_gnt = (state_q == S_DBG);
  assign timeout = timeout_q;

  always_comb begin
    owner       = 2'b00;
    bus_address = '0;
    bus_outdata = '0;
    bus_load    = 1'b0;
    bus_store   = 1'b0;
    cpu_indata  = '0;
    dma_indata  = '0;
    dbg_indata  = '0;
    case (state_q)
      S_CPU: begin
        owner       = 2'b01;
        bus_address = cpu_address;
        bus_outdata = cpu_outdata;
        bus_load    = cpu_load;
        bus_store   = cpu_store;
        cpu_indata  = bus_indata;
      end
      S_DMA: begin
        owner       = 2'b10;
        bus_address = dma_address;
        bus_outdata = dma_outdata;
        bus_load    = dma_load;
        bus_store   = dma_store;
        dma_indata  = bus_indata;
      end
      S_DBG: begin
        owner       = 2'b11;
        bus_address = dbg_address;
        bus_outdata = dbg_outdata;
        bus_load    = dbg_load;
        bus_store   = dbg_store;
        dbg_indata  = bus_indata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: one instance with a turnaround gap and short
// hold limit, one with back-to-back switching; both share the same master stimulus.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, dma_req, dbg_req;
  logic [15:0] cpu_address = 16'hC123, dma_address = 16'hFE00, dbg_address = 16'h8000;
  logic [7:0]  cpu_outdata = 8'h11, dma_outdata = 8'h22, dbg_outdata = 8'h33;
  logic        cpu_load = 1'b1, cpu_store = 1'b0;
  logic        dma_load = 1'b0, dma_store = 1'b1;
  logic        dbg_load = 1'b1, dbg_store = 1'b1;
  logic [7:0]  bus_indata = 8'h5A;

  logic        gC[2], gM[2], gG[2];
  logic [7:0]  inC[2], inM[2], inG[2];
  logic [15:0] bAddr[2];
  logic [7:0]  bOut[2];
  logic        bLd[2], bSt[2], tmo[2];
  logic [1:0]  own[2];

  int totalChecks = 0;
  int badChecks   = 0;

  typedef struct {
    int         dut;
    logic [1:0] owner;
    logic       tmo;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  bus_arbiter #(.TURNAROUND(1), .MAX_HOLD(4)) dut0 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_gnt(gC[0]), .cpu_address(cpu_address), .cpu_outdata(cpu_outdata),
    .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_indata(inC[0]),
    .dma_req(dma_req), .dma_gnt(gM[0]), .dma_address(dma_address), .dma_outdata(dma_outdata),
    .dma_load(dma_load), .dma_store(dma_store), .dma_indata(inM[0]),
    .dbg_req(dbg_req), .dbg_gnt(gG[0]), .dbg_address(dbg_address), .dbg_outdata(dbg_outdata),
    .dbg_load(dbg_load), .dbg_store(dbg_store), .dbg_indata(inG[0]),
    .bus_address(bAddr[0]), .bus_outdata(bOut[0]), .bus_load(bLd[0]), .bus_store(bSt[0]),
    .bus_indata(bus_indata), .owner(own[0]), .timeout(tmo[0])
  );

  bus_arbiter #(.TURNAROUND(0), .MAX_HOLD(4)) dut1 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_gnt(gC[1]), .cpu_address(cpu_address), .cpu_outdata(cpu_outdata),
    .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_indata(inC[1]),
    .dma_req(dma_req), .dma_gnt(gM[1]), .dma_address(dma_address), .dma_outdata(dma_outdata),
    .dma_load(dma_load), .dma_store(dma_store), .dma_indata(inM[1]),
    .dbg_req(dbg_req), .dbg_gnt(gG[1]), .dbg_address(dbg_address), .dbg_outdata(dbg_outdata),
    .dbg_load(dbg_load), .dbg_store(dbg_store), .dbg_indata(inG[1]),
    .bus_address(bAddr[1]), .bus_outdata(bOut[1]), .bus_load(bLd[1]), .bus_store(bSt[1]),
    .bus_indata(bus_indata), .owner(own[1]), .timeout(tmo[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    totalChecks++;
    if (got !== want) begin
      badChecks++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Expected bus-side values follow directly from which master is supposed to own the bus.
  task automatic popAndCheck();
    exp_t        e;
    logic [15:0] wAddr;
    logic [7:0]  wOut;
    logic        wLd, wSt;
    int          d;
    if (sb.size() == 0) begin
      checkOutput("scoreboardEmpty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    d = e.dut;
    case (e.owner)
      2'b01:   begin wAddr = 16'hC123; wOut = 8'h11; wLd = 1'b1; wSt = 1'b0; end
      2'b10:   begin wAddr = 16'hFE00; wOut = 8'h22; wLd = 1'b0; wSt = 1'b1; end
      2'b11:   begin wAddr = 16'h8000; wOut = 8'h33; wLd = 1'b1; wSt = 1'b1; end
      default: begin wAddr = 16'h0000; wOut = 8'h00; wLd = 1'b0; wSt = 1'b0; end
    endcase
    checkOutput({e.tag, ".owner"}, 32'(own[d]), 32'(e.owner));
    checkOutput({e.tag, ".gnt"}, 32'({gG[d], gM[d], gC[d]}),
                32'({e.owner == 2'b11, e.owner == 2'b10, e.owner == 2'b01}));
    checkOutput({e.tag, ".busAddr"}, 32'(bAddr[d]), 32'(wAddr));
    checkOutput({e.tag, ".busOut"}, 32'(bOut[d]), 32'(wOut));
    checkOutput({e.tag, ".busStrobes"}, 32'({bLd[d], bSt[d]}), 32'({wLd, wSt}));
    checkOutput({e.tag, ".cpuIn"}, 32'(inC[d]), (e.owner == 2'b01) ? 32'h5A : 32'h0);
    checkOutput({e.tag, ".dmaIn"}, 32'(inM[d]), (e.owner == 2'b10) ? 32'h5A : 32'h0);
    checkOutput({e.tag, ".dbgIn"}, 32'(inG[d]), (e.owner == 2'b11) ? 32'h5A : 32'h0);
    checkOutput({e.tag, ".timeout"}, 32'(tmo[d]), 32'(e.tmo));
  endtask

  task automatic pushExpected(input int d, input logic [1:0] o, input logic t, input string tag);
    exp_t e;
    e.dut = d; e.owner = o; e.tmo = t; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int d, input logic c, input logic m, input logic g,
                               input logic [1:0] expOwner, input logic expTmo, input string tag);
    cpu_req = c;
    dma_req = m;
    dbg_req = g;
    pushExpected(d, expOwner, expTmo, tag);
    @(posedge clock);
    #1;
    popAndCheck();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    cpu_req = 1'b1;
    dma_req = 1'b1;
    dbg_req = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    pushExpected(0, 2'b00, 1'b0, "rstHeld0");
    popAndCheck();
    pushExpected(1, 2'b00, 1'b0, "rstHeld1");
    popAndCheck();
    reset = 1'b0;

    applyStimulus(0, 1, 1, 0, 2'b10, 0, "rstRelease");
    applyStimulus(0, 1, 0, 0, 2'b00, 0, "dmaDrop");
    applyStimulus(0, 1, 0, 0, 2'b01, 0, "cpuGrant");
    applyStimulus(0, 1, 0, 0, 2'b01, 0, "cpuHold");
    applyStimulus(0, 1, 1, 0, 2'b00, 0, "cpuPreempt");
    applyStimulus(0, 1, 1, 0, 2'b10, 0, "dmaAfterTurn");
    applyStimulus(0, 0, 1, 0, 2'b10, 0, "dmaRead");
    applyStimulus(0, 0, 0, 0, 2'b00, 0, "dmaRelease");
    applyStimulus(0, 0, 0, 0, 2'b00, 0, "idle");

    applyStimulus(0, 0, 1, 1, 2'b11, 0, "prioDbg");
    applyStimulus(0, 0, 1, 0, 2'b00, 0, "dbgDrop");
    applyStimulus(0, 0, 1, 0, 2'b10, 0, "prioDma");

    applyStimulus(0, 1, 1, 0, 2'b10, 0, "cpuWaits");
    applyStimulus(0, 0, 0, 0, 2'b00, 0, "cpuGone");
    applyStimulus(0, 0, 0, 0, 2'b00, 0, "cpuForgotten");

    applyStimulus(0, 1, 0, 0, 2'b01, 0, "sameEdgeCpu");
    applyStimulus(0, 0, 0, 1, 2'b00, 0, "sameEdgeTurn");
    applyStimulus(0, 0, 0, 1, 2'b11, 0, "sameEdgeDbg");
    applyStimulus(0, 0, 0, 0, 2'b00, 0, "sameEdgeRel");
    applyStimulus(0, 0, 0, 0, 2'b00, 0, "sameEdgeIdle");

    applyStimulus(0, 0, 1, 0, 2'b10, 0, "holdGrant");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 2'b10, 0, "holdCount");
    applyStimulus(0, 0, 1, 1, 2'b00, 1, "forcedDma");
    applyStimulus(0, 0, 1, 1, 2'b11, 1, "dbgAfterForce");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 2'b11, 1, "dbgHold");
    applyStimulus(0, 0, 1, 1, 2'b00, 1, "forcedDbg");
    applyStimulus(0, 0, 1, 0, 2'b10, 1, "dmaRecompetes");
    applyStimulus(0, 0, 0, 0, 2'b00, 1, "timeoutSticky");
    applyStimulus(0, 1, 0, 0, 2'b01, 1, "cpuBeforeReset");

    #2 reset = 1'b1;
    #1;
    pushExpected(0, 2'b00, 1'b0, "rstAsync0");
    popAndCheck();
    pushExpected(1, 2'b00, 1'b0, "rstAsync1");
    popAndCheck();
    @(posedge clock);
    #1;
    reset = 1'b0;

    applyStimulus(1, 1, 0, 0, 2'b01, 0, "z.cpuGrant");
    applyStimulus(1, 1, 0, 0, 2'b01, 0, "z.cpuHold");
    applyStimulus(1, 1, 1, 0, 2'b10, 0, "z.directSwitch");
    applyStimulus(1, 0, 0, 0, 2'b00, 0, "z.release");
    applyStimulus(1, 0, 1, 0, 2'b10, 0, "z.dmaGrant");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 1, 2'b10, 0, "z.holdCount");
    applyStimulus(1, 0, 1, 1, 2'b11, 1, "z.forcedSwitch");
    applyStimulus(1, 0, 0, 1, 2'b11, 1, "z.dbgStays");
    applyStimulus(1, 0, 0, 0, 2'b00, 1, "z.dbgRelease");

    if (sb.size() != 0) checkOutput("scoreboardLeftover", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
